// File: rtl/feature_packer.sv
`default_nettype none
// ============================================================================
// Module      : feature_packer
// Description : Packs a serial stream of signed BW-bit feature coefficients
//               into VECTOR_LEN-wide vectors and frames them into utterances
//               of FRAME_LEN vectors (last_o marks the final vector).
//               Coefficient k of a vector lands in data_o[(k+1)*BW-1 : k*BW].
//               Storage is a partial-vector accumulator plus an output
//               register, so input keeps flowing while an output is pending.
// Ports       : clk_i        - clock, rising edge
//               rst_i        - synchronous active-high reset
//               data_i       - serial signed coefficient
//               valid_i      - data_i valid
//               ready_o      - packer accepts data_i this cycle
//               flush_i      - synchronous abort of the current utterance
//               data_o       - packed vector
//               valid_o      - data_o / last_o valid
//               last_o       - data_o is the final vector of the utterance
//               ready_i      - downstream accepts data_o
//               frame_idx_o  - index of the vector currently being assembled
// Revision    : 1.0 - initial release
// ============================================================================
module feature_packer #(
    parameter int  BW         = 8,
    parameter int  VECTOR_LEN = 13,
    parameter int  FRAME_LEN  = 50,
    localparam int FW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic signed [BW-1:0]         data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic                         flush_i,
    output logic [BW*VECTOR_LEN-1:0]     data_o,
    output logic                         valid_o,
    output logic                         last_o,
    input  logic                         ready_i,
    output logic [FW-1:0]                frame_idx_o
);

    localparam int              CW           = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam int              VW           = BW * VECTOR_LEN;
    localparam logic [CW-1:0]   c_coef_last  = CW'(VECTOR_LEN - 1);
    localparam logic [FW-1:0]   c_frame_last = FW'(FRAME_LEN - 1);

    logic [CW-1:0] r_coef_cnt;
    logic [FW-1:0] r_frame_cnt;
    logic [VW-1:0] r_acc;
    logic [VW-1:0] r_data;
    logic          r_valid;
    logic          r_last;

    logic          w_out_xfer;
    logic          w_in_xfer;
    logic          w_complete;
    logic [VW-1:0] w_vec;

    // Only the final coefficient needs the output register, so stall just
    // that one while a vector is still waiting to be consumed. A flush
    // blocks all input for its cycle.
    assign ready_o    = ~flush_i & ~((r_coef_cnt == c_coef_last) & r_valid & ~ready_i);
    assign w_in_xfer  = valid_i & ready_o;
    assign w_out_xfer = r_valid & ready_i;
    assign w_complete = w_in_xfer & (r_coef_cnt == c_coef_last);

    // The completing coefficient bypasses the accumulator straight into the
    // top slot so the full vector loads into the output register in one edge.
    always_comb begin
        w_vec             = r_acc;
        w_vec[VW-1 -: BW] = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_coef_cnt  <= '0;
            r_frame_cnt <= '0;
            r_acc       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                for (int k = 0; k < VECTOR_LEN; k++) begin
                    if (r_coef_cnt == CW'(k)) begin
                        r_acc[k*BW +: BW] <= data_i;
                    end
                end
                r_coef_cnt <= w_complete ? '0 : r_coef_cnt + CW'(1);
            end

            // A completion in the same cycle as an output transfer simply
            // overwrites the consumed vector, keeping valid_o high.
            if (w_complete) begin
                r_data      <= w_vec;
                r_valid     <= 1'b1;
                r_last      <= (r_frame_cnt == c_frame_last);
                r_frame_cnt <= (r_frame_cnt == c_frame_last) ? '0 : r_frame_cnt + FW'(1);
            end else if (w_out_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign last_o      = r_last;
    assign frame_idx_o = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_feature_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_feature_packer
// Description : Directed self-checking bench for feature_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_packer;

    localparam int BW = 8;
    localparam int VL = 13;
    localparam int FL = 50;
    localparam int VW = BW * VL;
    localparam int FW = 6;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic signed [BW-1:0] data_i = '0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic                 flush_i = 1'b0;
    logic [VW-1:0]        data_o;
    logic                 valid_o;
    logic                 last_o;
    logic                 ready_i = 1'b0;
    logic [FW-1:0]        frame_idx_o;

    int errors = 0;
    int checks = 0;

    feature_packer #(.BW(BW), .VECTOR_LEN(VL), .FRAME_LEN(FL)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .flush_i     (flush_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .last_o      (last_o),
        .ready_i     (ready_i),
        .frame_idx_o (frame_idx_o)
    );

    always #5 clk_i = ~clk_i;

    // Vector whose element k holds base+k (8-bit wrap).
    function automatic logic [VW-1:0] make_vec(input logic [7:0] base);
        logic [VW-1:0] v;
        for (int k = 0; k < VL; k++) v[k*BW +: BW] = base + 8'(k);
        return v;
    endfunction

    // Present one input, note whether it is accepted, then advance one edge.
    task automatic drive(input logic v, input logic [7:0] d, output logic acc);
        data_i  = d;
        valid_i = v;
        #1;
        acc = v & ready_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h5A;
        ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", last_o); end
        checks++; if (data_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_o); end
        checks++; if (frame_idx_o !== '0) begin errors++; $display("FAIL reset_frame_idx: got %0d expected 0", frame_idx_o); end
        rst_i   = 1'b0;
        valid_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    endtask

    task automatic test_basic_packing();
        logic a;
        int   early_valid = 0;
        int   rejected = 0;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < VL; i++) begin
            drive(1'b1, 8'(i + 1), a);
            if (!a) rejected++;
            if (i < VL - 1 && valid_o !== 1'b0) early_valid++;
        end
        valid_i = 1'b0;
        checks++; if (rejected != 0 || early_valid != 0) begin errors++; $display("FAIL basic_flow: got rejected=%0d early_valid=%0d expected 0/0", rejected, early_valid); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", valid_o); end
        checks++; if (data_o[7:0] !== 8'h01) begin errors++; $display("FAIL basic_slot0: got %h expected 01", data_o[7:0]); end
        checks++; if (data_o[103:96] !== 8'h0D) begin errors++; $display("FAIL basic_slot12: got %h expected 0d", data_o[103:96]); end
        checks++; if (data_o !== make_vec(8'h01)) begin errors++; $display("FAIL basic_vector: got %h expected %h", data_o, make_vec(8'h01)); end
        checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL basic_last: got %b expected 0", last_o); end
        @(posedge clk_i);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_width: got %b expected 0", valid_o); end
    endtask

    task automatic test_framing();
        logic a;
        int nvec = 0, nlast = 0, last_at = 0, bad_data = 0, bad_idx = 0, rejected = 0;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < VL * FL; i++) begin
            drive(1'b1, 8'(i), a);
            if (!a) rejected++;
            if (valid_o === 1'b1) begin
                nvec++;
                if (data_o !== make_vec(8'((nvec - 1) * VL))) bad_data++;
                if (frame_idx_o !== FW'(nvec % FL)) bad_idx++;
                if (last_o === 1'b1) begin nlast++; last_at = nvec; end
            end
        end
        valid_i = 1'b0;
        checks++; if (nvec != FL) begin errors++; $display("FAIL frame_count: got %0d expected %0d", nvec, FL); end
        checks++; if (nlast != 1 || last_at != FL) begin errors++; $display("FAIL frame_last: got count=%0d at=%0d expected 1 at %0d", nlast, last_at, FL); end
        checks++; if (bad_data != 0 || bad_idx != 0 || rejected != 0) begin errors++; $display("FAIL frame_content: got bad_data=%0d bad_idx=%0d rejected=%0d expected 0", bad_data, bad_idx, rejected); end
        checks++; if (frame_idx_o !== '0) begin errors++; $display("FAIL frame_idx_wrap: got %0d expected 0", frame_idx_o); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_backpressure();
        logic a;
        int accepted = 0, unstable = 0;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < VL; i++) drive(1'b1, 8'(8'h10 + i), a);
        ready_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 8'(8'h20 + accepted), a);
            if (a) accepted++;
            if (valid_o !== 1'b1 || data_o !== make_vec(8'h10)) unstable++;
        end
        checks++; if (accepted != VL - 1) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, VL - 1); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        data_i  = 8'h2C;
        valid_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", ready_o); end
        ready_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b expected 1", ready_o); end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || data_o !== make_vec(8'h20)) begin errors++; $display("FAIL bp_second_vector: got v=%b %h expected 1 %h", valid_o, data_o, make_vec(8'h20)); end
        @(posedge clk_i);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got %b expected 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        logic a;
        int nvalid = 0, first_at = -1, second_at = -1, rejected = 0, bad_data = 0;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 2 * VL; i++) begin
            drive(1'b1, 8'(8'hF0 + i), a);
            if (!a) rejected++;
            if (valid_o === 1'b1) begin
                nvalid++;
                if (nvalid == 1) begin first_at = i; if (data_o !== make_vec(8'hF0)) bad_data++; end
                if (nvalid == 2) begin second_at = i; if (data_o !== make_vec(8'hFD)) bad_data++; end
            end
        end
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        if (valid_o === 1'b1) nvalid++;
        checks++; if (rejected != 0) begin errors++; $display("FAIL b2b_ready: got %0d rejected expected 0", rejected); end
        checks++; if (nvalid != 2) begin errors++; $display("FAIL b2b_valid_cycles: got %0d expected 2", nvalid); end
        checks++; if (second_at - first_at != VL) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", second_at - first_at, VL); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL b2b_data: got %0d bad vectors expected 0", bad_data); end
    endtask

    task automatic test_flush();
        logic a;
        int bad_idx = 0, leak = 0;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 2 * VL; i++) drive(1'b1, 8'(i), a);
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h30 + i), a);
        flush_i = 1'b1;
        data_i  = 8'hEE;
        valid_i = 1'b1;
        #1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", ready_o); end
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || frame_idx_o !== '0) begin errors++; $display("FAIL flush_state: got v=%b idx=%0d expected 0/0", valid_o, frame_idx_o); end
        for (int i = 0; i < VL; i++) begin
            if (frame_idx_o !== '0) bad_idx++;
            drive(1'b1, 8'(8'h40 + i), a);
            if (i < VL - 1 && valid_o !== 1'b0) leak++;
        end
        valid_i = 1'b0;
        checks++; if (bad_idx != 0 || leak != 0) begin errors++; $display("FAIL flush_assembly: got bad_idx=%0d leak=%0d expected 0/0", bad_idx, leak); end
        checks++; if (valid_o !== 1'b1 || data_o !== make_vec(8'h40)) begin errors++; $display("FAIL flush_vector: got v=%b %h expected 1 %h", valid_o, data_o, make_vec(8'h40)); end
        checks++; if (frame_idx_o !== FW'(1) || last_o !== 1'b0) begin errors++; $display("FAIL flush_frame: got idx=%0d last=%b expected 1/0", frame_idx_o, last_o); end
    endtask

    task automatic test_mid_reset();
        logic a;
        do_reset();
        ready_i = 1'b1;
        for (int i = 0; i < VL; i++) drive(1'b1, 8'(8'h60 + i), a);
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h70 + i), a);
        rst_i   = 1'b1;
        valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        checks++; if (valid_o !== 1'b0 || data_o !== '0 || frame_idx_o !== '0) begin errors++; $display("FAIL midrst_state: got v=%b d=%h idx=%0d expected 0/0/0", valid_o, data_o, frame_idx_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready_o); end
        ready_i = 1'b1;
        for (int i = 0; i < VL; i++) drive(1'b1, 8'(8'h50 + i), a);
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || data_o !== make_vec(8'h50)) begin errors++; $display("FAIL midrst_restart: got v=%b %h expected 1 %h", valid_o, data_o, make_vec(8'h50)); end
    endtask

    initial begin
        test_reset();
        test_basic_packing();
        test_framing();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/feature_packer.md
FEATURE_PACKER -- requirements
Module: feature_packer

Interface
REQ-001 Parameter BW, default 8: bit width of one signed feature coefficient.
REQ-002 Parameter VECTOR_LEN, default 13: coefficients per packed vector.
REQ-003 Parameter FRAME_LEN, default 50: vectors per utterance; the last vector of an utterance carries last_o.
REQ-004 Ports, in this order:
- clk_i  input  1  sole clock; all logic is on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- data_i  input  BW  signed coefficient, serial stream.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  the packer accepts data_i this cycle.
- flush_i  input  1  synchronous abort of the current utterance.
- data_o  output  BW*VECTOR_LEN  packed signed vector.
- valid_o  output  1  data_o and last_o are valid.
- last_o  output  1  data_o is vector FRAME_LEN-1 of the utterance.
- ready_i  input  1  the downstream consumer accepts data_o.
- frame_idx_o  output  clog2(FRAME_LEN)  index of the vector currently being assembled.

Function
REQ-005 An input transfer occurs in a cycle where valid_i and ready_o are both high; an output transfer occurs in a cycle where valid_o and ready_i are both high.
REQ-006 Coefficient counter coef_cnt runs 0..VECTOR_LEN-1:
- increments on each input transfer;
- wraps to 0 on the transfer made at VECTOR_LEN-1.
REQ-007 Slot mapping: the coefficient accepted at coef_cnt=k occupies data_o[(k+1)*BW-1 : k*BW], so element 0 sits at the LSBs.
REQ-008 The block holds two storage stages, a partial-vector accumulator and an output register; inputs are accepted while the output register holds an unconsumed vector.
REQ-009 Vector completion: the input transfer at coef_cnt=VECTOR_LEN-1 loads the full vector into the output register, and valid_o rises on the next cycle (latency 1 from the final coefficient).
REQ-010 ready_o = NOT (coef_cnt==VECTOR_LEN-1 AND valid_o AND NOT ready_i); this is combinational from ready_i and from registered state only.
REQ-011 Simultaneous completion and output transfer in the same cycle: the new vector replaces the old one, and valid_o stays high with no bubble.
REQ-012 valid_o falls after an output transfer unless a completion occurs in the same cycle.
REQ-013 While valid_o is high and ready_i is low, data_o, last_o and valid_o are held stable.
REQ-014 Frame counter frame_cnt runs 0..FRAME_LEN-1:
- increments on each vector load into the output register;
- wraps to 0 after FRAME_LEN-1.
- frame_idx_o = frame_cnt.
REQ-015 last_o is registered together with data_o and is high only for the vector loaded at frame_cnt=FRAME_LEN-1.
REQ-016 flush_i high in a cycle:
- on the next cycle coef_cnt=0, frame_cnt=0 and valid_o=0;
- the partial vector and the pending output vector are discarded;
- ready_o is forced low during the flush cycle.
REQ-017 flush_i takes priority over a simultaneous input transfer, output transfer or completion; no transfer is counted in that cycle.
REQ-018 data_i is not modified arithmetically; it is a bit-exact copy, with no sign extension or saturation.

Reset
REQ-019 rst_i high at a rising edge sets coef_cnt=0, frame_cnt=0, valid_o=0, last_o=0, data_o=0 and frame_idx_o=0.
REQ-020 ready_o reads 1 in the first cycle after rst_i deasserts.
REQ-021 rst_i asserted mid-vector or mid-utterance aborts it with the same result as flush_i; rst_i has priority over flush_i.

Verification
REQ-022 Basic packing: with ready_i=1, send 13 coefficients 0x01..0x0D back-to-back. Required: valid_o for exactly 1 cycle, 1 cycle after the 13th; data_o[7:0]=0x01 and data_o[103:96]=0x0D; last_o=0.
REQ-023 Utterance framing: with ready_i=1, stream 650 coefficients. Required: 50 output vectors; last_o only on vector 50; frame_idx_o returns to 0 afterwards.
REQ-024 Backpressure:
- Stimulus: ready_i=0 after the first vector completes; keep valid_i=1.
- Required: 12 more coefficients accepted; ready_o drops to 0 at coef_cnt=12; data_o stays stable.
- Stimulus: raise ready_i.
- Required: the second vector appears the cycle after the output transfer that frees the register; no coefficient is lost or duplicated.
REQ-025 Zero-bubble completion: ready_i=1 and continuous valid_i for 26 coefficients. Required: two vectors, each valid_o for 1 cycle, 13 cycles apart, and ready_o never deasserts.
REQ-026 Flush:
- Stimulus: flush_i pulsed after 7 coefficients of vector 3, with valid_i=1 in the same cycle.
- Required: that coefficient is dropped; the next 13 coefficients form a vector at frame_idx 0; no partial data leaks into data_o.
REQ-027 Mid-operation reset: rst_i asserted while valid_o=1 and ready_i=0. Required: valid_o=0 and data_o=0 next cycle, ready_o=1 after deassertion, and packing restarts at slot 0.
